traffic_conflict_monitor: RTL and testbench
===========================================

Name: traffic_conflict_monitor

Overview:
- Safety stage directly downstream of the two-approach traffic light controller.
- Consumes the NS and WE lamp codes (100 red, 010 yellow, 001 green) and passes them, registered, to the lamp drivers.
- Detects conflicting or malformed lamp codes. After a persistence filter it latches a fault, forces all-red flashing and holds the controller in reset.
- Returns to normal only after an operator clear and a clean recovery window.

Parameters:
PERSIST, 3, consecutive fault cycles required to trip (>=1)
FLASH_HALF, 8, cycles per flash half-period (>=1)
RECOVER, 16, consecutive clean cycles required in RECOVER before release (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
ns_in  input  3  NS lamp code from controller
we_in  input  3  WE lamp code from controller
clear  input  1  operator fault clear, level sampled each cycle
ns_out  output  3  NS lamp drive, registered
we_out  output  3  WE lamp drive, registered
fault  output  1  fault latched (high in FAULT_FLASH and RECOVER)
fault_code  output  2  01 conflict, 10 invalid code, 11 both, 00 none
ctrl_hold  output  1  active-high reset to upstream controller

Behaviour:
- Reset (rst low, asynchronous): state MONITOR; ns_out=we_out=100; fault=0; fault_code=00; ctrl_hold=0; all counters 0; flash phase on.
- Combinational conditions:
  - conflict = ns_in[2]==0 and we_in[2]==0 (neither head red).
  - invalid = ns_in or we_in not exactly one-hot.
  - bad = conflict or invalid.
- MONITOR:
  - ns_out/we_out <= ns_in/we_in, so latency is 1 cycle; malformed values also pass through.
  - Persistence counter increments while bad and clears to 0 on any cycle without bad.
  - Trip occurs on the edge ending the PERSIST-th consecutive bad cycle. On that edge:
    - state -> FAULT_FLASH
    - fault=1, ctrl_hold=1
    - fault_code = {invalid, conflict} of that cycle
    - flash counter=0, phase on, outputs 100/100
  - A faulty code is therefore visible on the outputs for PERSIST-1 cycles. With PERSIST=1 it is never visible.
  - clear is ignored in MONITOR.
- Flashing (FAULT_FLASH and RECOVER):
  - ns_out=we_out=100 when phase on, 000 when phase off.
  - Flash counter counts 0..FLASH_HALF-1, then wraps to 0 and toggles phase, so each phase lasts exactly FLASH_HALF cycles.
  - The counter and phase run continuously across FAULT_FLASH<->RECOVER transitions. They restart only on entry from MONITOR.
- FAULT_FLASH:
  - ctrl_hold=1.
  - clear high -> RECOVER on the next edge, regardless of bad. On that edge ctrl_hold<=0 and the recovery counter <=0.
- RECOVER:
  - ctrl_hold=0, fault stays 1, fault_code held.
  - Recovery counter increments on each clean cycle.
  - Any bad cycle -> FAULT_FLASH on that edge, with no persistence filter: ctrl_hold=1, fault_code = current {invalid, conflict}, recovery counter cleared.
  - Edge ending the RECOVER-th consecutive clean cycle -> MONITOR: fault=0, fault_code=00, persistence counter=0. Outputs resume pass-through from the next edge; they show the current input on that edge.
  - clear is ignored in RECOVER.
- Simultaneous clear and bad in FAULT_FLASH: RECOVER is entered. If bad persists, RECOVER returns to FAULT_FLASH one edge later.
- Counter widths: $clog2(param+1); no counter may overflow or wrap except the flash counter.
- Reset asserted mid-fault: immediate return to reset values, with no flash completion.

Test Plan:
- Reset release, then drive legal sequence 001/100, 010/100, 100/100, 100/001 -> outputs match one cycle later; fault=0, ctrl_hold=0 throughout.
- ns_in=001, we_in=001 for 2 cycles, then 100/001 -> 001/001 appears at outputs for 2 cycles; no trip; a later single bad cycle also does not trip (persistence counter was cleared).
- ns_in=001, we_in=010 held 3 cycles -> on 3rd edge fault=1, fault_code=01, ctrl_hold=1; outputs 100/100 for 8 cycles, 000/000 for 8 cycles, repeating.
- ns_in=000, we_in=100 held 3 cycles -> fault_code=10. Separately ns_in=011, we_in=010 held 3 cycles -> fault_code=11.
- In FAULT_FLASH pulse clear 1 cycle, then drive 001/100 for 16 cycles -> ctrl_hold falls on the edge after clear; flashing continues without phase glitch; on the 16th clean edge fault=0, fault_code=00, pass-through resumes. Variant: inject 001/001 at clean cycle 10 -> same-edge return to FAULT_FLASH, ctrl_hold=1, fault_code=01.
- Assert rst low mid-flash, between clock edges -> outputs 100/100, fault=0, fault_code=00, ctrl_hold=0 immediately; after release, normal pass-through resumes.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the two-approach light controller and the lamp drivers:
// passes lamp codes through, trips to all-red flashing on persistent conflicts.
module traffic_conflict_monitor #(
   parameter int PERSIST    = 3,
   parameter int FLASH_HALF = 8,
   parameter int RECOVER    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] ns_in,
   input  logic [2:0] we_in,
   input  logic       clear,
   output logic [2:0] ns_out,
   output logic [2:0] we_out,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic       ctrl_hold
);

   localparam int PW = $clog2(PERSIST + 1);
   localparam int FW = $clog2(FLASH_HALF + 1);
   localparam int RW = $clog2(RECOVER + 1);
   localparam logic [2:0] RED  = 3'b100;
   localparam logic [2:0] DARK = 3'b000;

   typedef enum logic [1:0] {
      S_MONITOR,
      S_FLASH,
      S_RECOVER
   } state_t;

   state_t        state;
   logic [PW-1:0] pcnt;
   logic [FW-1:0] fcnt;
   logic [RW-1:0] rcnt;
   logic          phase;

   function automatic logic onehot3(input logic [2:0] c);
      return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
   endfunction

   logic          conflict, invalid, bad;
   logic          fwrap, phase_nx;
   logic [FW-1:0] fcnt_nx;
   logic [2:0]    flash_code;

   assign conflict   = ~ns_in[2] & ~we_in[2];
   assign invalid    = ~onehot3(ns_in) | ~onehot3(we_in);
   assign bad        = conflict | invalid;

   // Flash timebase free-runs through FAULT_FLASH and RECOVER alike
   assign fwrap      = (fcnt == FW'(FLASH_HALF - 1));
   assign fcnt_nx    = fwrap ? '0 : fcnt + 1'b1;
   assign phase_nx   = phase ^ fwrap;
   assign flash_code = phase_nx ? RED : DARK;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_MONITOR;
         ns_out     <= RED;
         we_out     <= RED;
         fault      <= 1'b0;
         fault_code <= 2'b00;
         ctrl_hold  <= 1'b0;
         pcnt       <= '0;
         fcnt       <= '0;
         rcnt       <= '0;
         phase      <= 1'b1;
      end else begin
         case (state)
            S_MONITOR: begin
               ns_out <= ns_in;
               we_out <= we_in;
               if (bad) begin
                  if (pcnt == PW'(PERSIST - 1)) begin
                     state      <= S_FLASH;
                     fault      <= 1'b1;
                     ctrl_hold  <= 1'b1;
                     fault_code <= {invalid, conflict};
                     fcnt       <= '0;
                     phase      <= 1'b1;
                     pcnt       <= '0;
                     ns_out     <= RED;
                     we_out     <= RED;
                  end else begin
                     pcnt <= pcnt + 1'b1;
                  end
               end else begin
                  pcnt <= '0;
               end
            end
            S_FLASH: begin
               fcnt   <= fcnt_nx;
               phase  <= phase_nx;
               ns_out <= flash_code;
               we_out <= flash_code;
               if (clear) begin
                  state     <= S_RECOVER;
                  ctrl_hold <= 1'b0;
                  rcnt      <= '0;
               end
            end
            S_RECOVER: begin
               fcnt   <= fcnt_nx;
               phase  <= phase_nx;
               ns_out <= flash_code;
               we_out <= flash_code;
               // Any relapse re-trips immediately; no persistence filter here
               if (bad) begin
                  state      <= S_FLASH;
                  ctrl_hold  <= 1'b1;
                  fault_code <= {invalid, conflict};
                  rcnt       <= '0;
               end else if (rcnt == RW'(RECOVER - 1)) begin
                  state      <= S_MONITOR;
                  fault      <= 1'b0;
                  fault_code <= 2'b00;
                  pcnt       <= '0;
                  rcnt       <= '0;
               end else begin
                  rcnt <= rcnt + 1'b1;
               end
            end
            default: state <= S_MONITOR;
         endcase
      end
   end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed scenarios then random traffic,
// every cycle compared against a cycle-count based reference model.
module tb_traffic_conflict_monitor;

   localparam int PERSIST    = 3;
   localparam int FLASH_HALF = 8;
   localparam int RECOVER    = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] ns_in = 3'b100;
   logic [2:0] we_in = 3'b100;
   logic       clear = 1'b0;
   logic [2:0] ns_out, we_out;
   logic       fault, ctrl_hold;
   logic [1:0] fault_code;

   traffic_conflict_monitor #(
      .PERSIST(PERSIST), .FLASH_HALF(FLASH_HALF), .RECOVER(RECOVER)
   ) dut (
      .clk(clk), .rst(rst), .ns_in(ns_in), .we_in(we_in), .clear(clear),
      .ns_out(ns_out), .we_out(we_out), .fault(fault),
      .fault_code(fault_code), .ctrl_hold(ctrl_hold)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int cyc    = 0;

   // Reference model: mode 0 normal, 1 flashing/held, 2 recovering
   int         mode, bad_run, clean_run, flash_age;
   logic [2:0] e_ns, e_we;
   logic       e_fault, e_hold;
   logic [1:0] e_code;

   task automatic model_reset();
      mode = 0; bad_run = 0; clean_run = 0; flash_age = 0;
      e_ns = 3'b100; e_we = 3'b100; e_fault = 1'b0; e_hold = 1'b0; e_code = 2'b00;
   endtask

   function automatic logic [2:0] flash_at(input int age);
      return (((age / FLASH_HALF) % 2) == 0) ? 3'b100 : 3'b000;
   endfunction

   task automatic model_edge(input logic [2:0] n, input logic [2:0] w, input logic c);
      logic con, inv, b;
      con = (n < 4) && (w < 4);
      inv = ($countones(n) != 1) || ($countones(w) != 1);
      b   = con || inv;
      if (mode == 0) begin
         e_ns = n; e_we = w;
         if (b) begin
            bad_run++;
            if (bad_run == PERSIST) begin
               mode = 1; e_fault = 1'b1; e_hold = 1'b1; e_code = {inv, con};
               flash_age = 0; e_ns = 3'b100; e_we = 3'b100; bad_run = 0;
            end
         end else begin
            bad_run = 0;
         end
      end else begin
         flash_age++;
         e_ns = flash_at(flash_age); e_we = flash_at(flash_age);
         if (mode == 1) begin
            if (c) begin mode = 2; e_hold = 1'b0; clean_run = 0; end
         end else if (b) begin
            mode = 1; e_hold = 1'b1; e_code = {inv, con}; clean_run = 0;
         end else begin
            clean_run++;
            if (clean_run == RECOVER) begin
               mode = 0; e_fault = 1'b0; e_code = 2'b00; bad_run = 0;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
   endtask

   task automatic check_all();
      chk("ns_out", ns_out, e_ns);
      chk("we_out", we_out, e_we);
      chk("fault", {2'b00, fault}, {2'b00, e_fault});
      chk("fault_code", {1'b0, fault_code}, {1'b0, e_code});
      chk("ctrl_hold", {2'b00, ctrl_hold}, {2'b00, e_hold});
   endtask

   task automatic step(input logic [2:0] n, input logic [2:0] w, input logic c);
      ns_in = n; we_in = w; clear = c;
      @(posedge clk);
      cyc++;
      model_edge(n, w, c);
      #1;
      check_all();
   endtask

   task automatic rand_step(input int bad_pct, input int clr_pct);
      logic [2:0] n, w;
      logic [2:0] legal [3];
      legal[0] = 3'b001; legal[1] = 3'b010; legal[2] = 3'b100;
      if ($urandom_range(99) < bad_pct) begin
         n = 3'($urandom); w = 3'($urandom);
      end else begin
         n = legal[$urandom_range(2)];
         w = (n == 3'b100) ? legal[$urandom_range(2)] : 3'b100;
      end
      step(n, w, $urandom_range(99) < clr_pct);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog cycle=%0d observed=timeout expected=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      #12;
      check_all();
      @(negedge clk); rst = 1'b1;

      // Legal sequence passes through with one cycle latency
      step(3'b001, 3'b100, 1'b0);
      step(3'b010, 3'b100, 1'b0);
      step(3'b100, 3'b100, 1'b0);
      step(3'b100, 3'b001, 1'b0);

      // Short conflict below persistence, then an isolated bad cycle
      step(3'b001, 3'b001, 1'b0);
      step(3'b001, 3'b001, 1'b0);
      step(3'b100, 3'b001, 1'b0);
      step(3'b100, 3'b001, 1'b0);
      step(3'b010, 3'b010, 1'b0);
      step(3'b100, 3'b010, 1'b0);

      // Conflict trip, then two full flash periods
      repeat (3) step(3'b001, 3'b010, 1'b0);
      repeat (34) step(3'b001, 3'b100, 1'b0);

      // Clear with clean recovery back to pass-through
      step(3'b001, 3'b100, 1'b1);
      repeat (16) step(3'b001, 3'b100, 1'b0);
      repeat (3) step(3'b010, 3'b100, 1'b0);

      // Invalid-only trip, then recovery interrupted at clean cycle 10
      repeat (3) step(3'b000, 3'b100, 1'b0);
      repeat (5) step(3'b100, 3'b100, 1'b0);
      step(3'b100, 3'b001, 1'b1);
      repeat (9) step(3'b001, 3'b100, 1'b0);
      step(3'b001, 3'b001, 1'b0);
      repeat (4) step(3'b001, 3'b100, 1'b0);

      // Clear coinciding with a bad code, then bad persisting in RECOVER
      step(3'b011, 3'b010, 1'b1);
      step(3'b011, 3'b010, 1'b0);
      step(3'b100, 3'b100, 1'b1);
      repeat (17) step(3'b100, 3'b010, 1'b0);

      // Conflict plus invalid trip
      repeat (3) step(3'b011, 3'b010, 1'b0);
      repeat (5) step(3'b100, 3'b100, 1'b0);

      // Asynchronous reset between edges while flashing
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk); rst = 1'b1;
      step(3'b001, 3'b100, 1'b0);
      step(3'b100, 3'b010, 1'b0);

      // Randomised traffic with occasional faults and clears
      repeat (1500) rand_step(10, 8);
      repeat (400) rand_step(40, 25);
      repeat (300) rand_step(3, 15);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
